dump_ctrl: RTL
==============

Name: dump_ctrl

Overview:
Sequences a channel dump once the command decoder issues a dump pulse.
- Fetches the offset and gain calibration bytes for the selected channel/AFE-gain pair from the calibration EEPROM over SPI, and loads them into the gain-corrector flops.
- Then walks the capture RAM from the oldest sample with wrap-around and streams each corrected sample out the UART, one byte per handshake.
- Sits between the command decoder, the SPI master (EEPROM slave), the capture RAM and the UART transmitter.

Parameters:
DEPTH, 384, number of samples stored per channel in capture RAM
ADDR_W, 9, RAM address width; must satisfy 2^ADDR_W >= DEPTH
RAM_LAT, 1, RAM read latency in clocks; corr_data is valid RAM_LAT clocks after ram_en

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
dump  in  1  one-clock start pulse from command decoder
dump_ch  in  2  channel to dump; 00=ch1, 01=ch2, 10=ch3, 11=reserved
ch1_AFEgain  in  3  current AFE gain of ch1
ch2_AFEgain  in  3  current AFE gain of ch2
ch3_AFEgain  in  3  current AFE gain of ch3
start_addr  in  ADDR_W  address of oldest sample, range 0..DEPTH-1
SPI_done  in  1  SPI transaction complete; EEP_data valid in the same cycle
wrt_SPI  out  1  one-clock SPI start pulse
SPI_data  out  16  SPI word
ss  out  3  slave select; 3'b100 whenever busy
flopOffset  out  1  one-clock load of EEP_data into the offset register
flopGain  out  1  one-clock load of EEP_data into the gain register
ram_en  out  1  RAM read enable
ram_addr  out  ADDR_W  RAM read address
corr_data  in  8  gain-corrected RAM read data
send_resp  out  1  one-clock UART transmit start
resp_data  out  8  byte to transmit, registered
resp_sent  in  1  UART byte complete
busy  out  1  dump in progress
dump_done  out  1  one-clock pulse at completion

Behaviour:
Reset values:
- All outputs 0, except ss=3'b000.
- State IDLE; sample counter 0.
- Reset mid-dump returns to IDLE immediately; no dump_done pulse is issued.

IDLE:
- On dump with dump_ch!=2'b11, latch ch=dump_ch, g=the selected chN_AFEgain, base=start_addr; go to OFF_CMD.
- dump with dump_ch=11 is ignored.
- dump while busy is ignored.

EEPROM address: eaddr={ch, g, lsb}, 6 bits. lsb=0 selects offset, lsb=1 selects gain.

EEPROM read sequence:
- OFF_CMD: wrt_SPI=1 for one clock, SPI_data={2'b00, eaddr(lsb=0), 8'h00}. Go to OFF_W1.
- OFF_W1: wait SPI_done, then wrt_SPI=1 with SPI_data=16'h0000. Go to OFF_W2.
- OFF_W2: on SPI_done, flopOffset=1 in that same cycle. Go to GAIN_CMD.
- GAIN_CMD / GAIN_W1 / GAIN_W2: identical with lsb=1. flopGain=1 on the final SPI_done. Go to RD.
- SPI_data holds its value between pulses.

Sample loop, for idx=0..DEPTH-1:
- RD: ram_en=1, ram_addr=(base+idx) wrapped: if base+idx>=DEPTH, subtract DEPTH. Compute in ADDR_W+1 bits.
- LAT: wait RAM_LAT clocks.
- SEND: resp_data<=corr_data, send_resp=1 for one clock.
- WTX: wait resp_sent. If idx==DEPTH-1 go to DONE; else idx++ and go to RD.
- Per-sample latency is RAM_LAT+3 clocks plus UART time.

DONE:
- dump_done=1 for one clock, busy=0 next cycle, return to IDLE.

Signal rules:
- busy=1 in every state except IDLE.
- ss=3'b100 from OFF_CMD through GAIN_W2; 3'b000 otherwise.
- SPI_done or resp_sent arriving in a state that does not wait for it is ignored.

Optional Feature:
DUMP_ABORT_EN
- Defined: adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort while busy sets a sticky abort_req.
  - The in-flight SPI transaction or UART byte is allowed to complete.
  - The FSM then goes to DONE instead of continuing; a pending second SPI word is not issued.
  - aborted=1 together with dump_done; it clears on the next dump.
  - abort in IDLE has no effect.
- Undefined: neither port exists; every dump runs to completion.

Decomposition:
Package dump_pkg holds:
- state_t enum: IDLE, OFF_CMD, OFF_W1, OFF_W2, GAIN_CMD, GAIN_W1, GAIN_W2, RD, LAT, SEND, WTX, DONE.
- Constants: SS_EEP=3'b100, EEP_RD_OP=2'b00.
- Function eep_addr(ch, g, lsb).

Sub-module dump_addr_gen: loadable modulo-DEPTH counter producing ram_addr and a last flag.

Test Plan:
- Reset mid-dump: assert rst during RD -> all outputs 0 within the same cycle, no dump_done, FSM back to IDLE.
- dump, dump_ch=01, ch2_AFEgain=3'b101:
  - SPI words are 16'h1A00, then 16'h0000, then 16'h1B00, then 16'h0000.
  - flopOffset fires on the 2nd SPI_done, flopGain on the 4th; ss=3'b100 throughout.
- DEPTH=384, start_addr=380, RAM model returns addr[7:0]:
  - 384 bytes sent: 0x7C,0x7D,0x7E,0x7F,0x00,... ending 0x7B.
  - ram_addr never reaches 384; dump_done fires once.
- dump_ch=11, or a second dump while busy -> no wrt_SPI, busy stays as before, no extra dump_done.
- Stalled UART: resp_sent delayed 50 clocks -> exactly one send_resp per byte, resp_data stable until resp_sent; spurious SPI_done during WTX is ignored.
- DUMP_ABORT_EN: abort during the 10th WTX -> exactly 10 bytes sent, then dump_done=1 and aborted=1; the next dump clears aborted.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared types and helpers for the channel dump sequencer.
// Used by dump_ctrl and dump_addr_gen.
package dump_pkg;

    // Sequencer states: EEPROM calibration fetch, then the RAM-to-UART sample loop.
    typedef enum logic [3:0] {
        IDLE,
        OFF_CMD,
        OFF_W1,
        OFF_W2,
        GAIN_CMD,
        GAIN_W1,
        GAIN_W2,
        RD,
        LAT,
        SEND,
        WTX,
        DONE
    } state_t;

    // Slave select pattern that addresses the calibration EEPROM.
    localparam logic [2:0] SS_EEP    = 3'b100;
    // Opcode in the top bits of the first SPI word for an EEPROM read.
    localparam logic [1:0] EEP_RD_OP = 2'b00;

    // Calibration byte address: channel, AFE gain, then offset(0)/gain(1) select.
    function automatic logic [5:0] eep_addr(input logic [1:0] ch,
                                            input logic [2:0] g,
                                            input logic       lsb);
        return {ch, g, lsb};
    endfunction

    // First SPI word of an EEPROM read: opcode, address, don't-care low byte.
    function automatic logic [15:0] eep_cmd(input logic [1:0] ch,
                                            input logic [2:0] g,
                                            input logic       lsb);
        return {EEP_RD_OP, eep_addr(ch, g, lsb), 8'h00};
    endfunction

endpackage

// File: rtl/dump_addr_gen.sv
// Modulo-DEPTH read address generator for the capture RAM.
// Loaded with the oldest-sample address; each step moves one sample forward,
// wrapping at DEPTH. 'last' marks the final sample of the dump.
module dump_addr_gen
    import dump_pkg::*;
#(
    parameter int DEPTH  = 384,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W:0]   sum_next;
    logic [ADDR_W:0]   wrap_next;

    // Hold the start address and the sample index within the dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg <= '0;
            idx_reg  <= '0;
        end else if (load) begin
            base_reg <= base;
            idx_reg  <= '0;
        end else if (step && (idx_reg != LAST_IDX)) begin
            idx_reg  <= idx_reg + 1'b1;
        end
    end

    // base+idx needs one extra bit before the wrap, since base can be DEPTH-1.
    always_comb begin
        sum_next  = {1'b0, base_reg} + {1'b0, idx_reg};
        wrap_next = (sum_next >= DEPTH_W) ? (sum_next - DEPTH_W) : sum_next;
    end

    assign addr = wrap_next[ADDR_W-1:0];
    assign last = (idx_reg == LAST_IDX);

endmodule

// File: rtl/dump_ctrl.sv
// Channel dump sequencer.
// On a dump pulse: reads the offset and gain calibration bytes for the chosen
// channel/AFE-gain pair from the EEPROM over SPI (two SPI words per byte),
// strobes them into the gain corrector, then streams DEPTH corrected samples
// from the capture RAM, oldest first, to the UART one byte per handshake.
// Build option: define DUMP_ABORT_EN to add the abort input and aborted flag.
module dump_ctrl
    import dump_pkg::*;
#(
    parameter int DEPTH   = 384,
    parameter int ADDR_W  = 9,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump,
    input  logic [1:0]        dump_ch,
    input  logic [2:0]        ch1_AFEgain,
    input  logic [2:0]        ch2_AFEgain,
    input  logic [2:0]        ch3_AFEgain,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              SPI_done,
    output logic              wrt_SPI,
    output logic [15:0]       SPI_data,
    output logic [2:0]        ss,
    output logic              flopOffset,
    output logic              flopGain,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        corr_data,
    output logic              send_resp,
    output logic [7:0]        resp_data,
    input  logic              resp_sent,
`ifdef DUMP_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              dump_done
);

    localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    state_t            state_reg;
    logic [1:0]        ch_reg;
    logic [2:0]        g_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic              wrt_spi_reg;
    logic [15:0]       spi_data_reg;
    logic [2:0]        ss_reg;
    logic              ram_en_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic              send_resp_reg;
    logic [7:0]        resp_data_reg;
    logic              busy_reg;
    logic              dump_done_reg;

    logic              dump_ok;
    logic              abort_now;
    logic              enter_done;
    logic              gen_step;
    logic              gen_last;
    logic [ADDR_W-1:0] gen_addr;
    logic [2:0]        sel_gain;

    // A dump is accepted only from IDLE and only for a real channel.
    assign dump_ok = dump && (dump_ch != 2'b11) && (state_reg == IDLE);

    // AFE gain of the channel being requested, captured when the dump starts.
    always_comb begin
        case (dump_ch)
            2'b00:   sel_gain = ch1_AFEgain;
            2'b01:   sel_gain = ch2_AFEgain;
            default: sel_gain = ch3_AFEgain;
        endcase
    end

`ifdef DUMP_ABORT_EN
    logic abort_req_reg;
    logic aborted_reg;

    // An abort in the same cycle as a completion still counts.
    assign abort_now = abort_req_reg | abort;
    assign aborted   = aborted_reg;

    // Sticky abort request while busy; aborted flag reported with dump_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_req_reg <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            if (dump_ok) begin
                abort_req_reg <= 1'b0;
                aborted_reg   <= 1'b0;
            end else if (state_reg == DONE) begin
                abort_req_reg <= 1'b0;
            end else if (abort && (state_reg != IDLE)) begin
                abort_req_reg <= 1'b1;
            end
            if (enter_done && abort_now) begin
                aborted_reg <= 1'b1;
            end
        end
    end
`else
    assign abort_now = 1'b0;
`endif

    // Early exit points: only where no SPI word or UART byte is in flight.
    always_comb begin
        enter_done = 1'b0;
        case (state_reg)
            OFF_CMD, GAIN_CMD, RD, SEND:
                enter_done = abort_now;
            OFF_W1, OFF_W2, GAIN_W1, GAIN_W2:
                enter_done = SPI_done && abort_now;
            WTX:
                enter_done = resp_sent && (abort_now || gen_last);
            default:
                enter_done = 1'b0;
        endcase
    end

    assign gen_step = (state_reg == WTX) && resp_sent && !enter_done;

    dump_addr_gen #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (dump_ok),
        .base (start_addr),
        .step (gen_step),
        .addr (gen_addr),
        .last (gen_last)
    );

    // Main sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ch_reg        <= '0;
            g_reg         <= '0;
            lat_cnt_reg   <= '0;
            wrt_spi_reg   <= 1'b0;
            spi_data_reg  <= '0;
            ss_reg        <= 3'b000;
            ram_en_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            send_resp_reg <= 1'b0;
            resp_data_reg <= '0;
            busy_reg      <= 1'b0;
            dump_done_reg <= 1'b0;
        end else begin
            wrt_spi_reg   <= 1'b0;
            ram_en_reg    <= 1'b0;
            send_resp_reg <= 1'b0;
            dump_done_reg <= 1'b0;
            if (enter_done) begin
                state_reg     <= DONE;
                ss_reg        <= 3'b000;
                dump_done_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (dump_ok) begin
                            ch_reg    <= dump_ch;
                            g_reg     <= sel_gain;
                            busy_reg  <= 1'b1;
                            ss_reg    <= SS_EEP;
                            state_reg <= OFF_CMD;
                        end
                    end
                    OFF_CMD: begin
                        wrt_spi_reg  <= 1'b1;
                        spi_data_reg <= eep_cmd(ch_reg, g_reg, 1'b0);
                        state_reg    <= OFF_W1;
                    end
                    OFF_W1: begin
                        if (SPI_done) begin
                            wrt_spi_reg  <= 1'b1;
                            spi_data_reg <= 16'h0000;
                            state_reg    <= OFF_W2;
                        end
                    end
                    OFF_W2: begin
                        if (SPI_done) state_reg <= GAIN_CMD;
                    end
                    GAIN_CMD: begin
                        wrt_spi_reg  <= 1'b1;
                        spi_data_reg <= eep_cmd(ch_reg, g_reg, 1'b1);
                        state_reg    <= GAIN_W1;
                    end
                    GAIN_W1: begin
                        if (SPI_done) begin
                            wrt_spi_reg  <= 1'b1;
                            spi_data_reg <= 16'h0000;
                            state_reg    <= GAIN_W2;
                        end
                    end
                    GAIN_W2: begin
                        if (SPI_done) begin
                            ss_reg    <= 3'b000;
                            state_reg <= RD;
                        end
                    end
                    RD: begin
                        ram_en_reg   <= 1'b1;
                        ram_addr_reg <= gen_addr;
                        lat_cnt_reg  <= '0;
                        state_reg    <= LAT;
                    end
                    LAT: begin
                        if (lat_cnt_reg == LAT_W'(RAM_LAT - 1)) state_reg <= SEND;
                        else lat_cnt_reg <= lat_cnt_reg + 1'b1;
                    end
                    SEND: begin
                        resp_data_reg <= corr_data;
                        send_resp_reg <= 1'b1;
                        state_reg     <= WTX;
                    end
                    WTX: begin
                        if (resp_sent) state_reg <= RD;
                    end
                    DONE: begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // EEP_data is only valid alongside SPI_done, so the load strobes follow it directly.
    assign flopOffset = (state_reg == OFF_W2)  && SPI_done;
    assign flopGain   = (state_reg == GAIN_W2) && SPI_done;

    assign wrt_SPI   = wrt_spi_reg;
    assign SPI_data  = spi_data_reg;
    assign ss        = ss_reg;
    assign ram_en    = ram_en_reg;
    assign ram_addr  = ram_addr_reg;
    assign send_resp = send_resp_reg;
    assign resp_data = resp_data_reg;
    assign busy      = busy_reg;
    assign dump_done = dump_done_reg;

endmodule
